ofmap_glb_collector: RTL and testbench

Output-side global buffer for the PE array. It accepts partial sums returned over the bus from the PE columns and either overwrites or accumulates them into an internal psum RAM at 1 beat/cycle. On host request it streams the finished ofmap out as ReLU'd, saturated DATA_WIDTH words over a valid/ready port. Data flows PE array → this block → host, the reverse of the ifmap/filter global buffer path.

---
 rtl/ofmap_glb_collector.sv | 251 +++++++++++++++++++++++++
 tb/tb_ofmap_glb_collector.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_glb_collector.sv
// Output-side global buffer: collects PE-array partial sums into a psum RAM (overwrite
// or accumulate) and drains the finished ofmap to the host as ReLU'd, saturated words.
module ofmap_glb_collector #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PSUM_WIDTH  = 32,
    parameter int unsigned NUM_COL     = 8,
    parameter int unsigned BUFFER_SIZE = 512,
    localparam int unsigned AW = $clog2(BUFFER_SIZE),
    localparam int unsigned CW = $clog2(NUM_COL) + 1
) (
    input  logic                         bus_clk,
    input  logic                         rstn,
    input  logic                         i_collect_start,
    input  logic                         i_psum_valid,
    output logic                         o_psum_ready,
    input  logic signed [PSUM_WIDTH-1:0] i_psum_data,
    input  logic [AW-1:0]                i_psum_addr,
    input  logic [CW-1:0]                i_psum_col_id,
    input  logic                         i_psum_accum,
    input  logic                         i_psum_last,
    input  logic                         i_drain_start,
    input  logic [AW:0]                  i_drain_len,
    input  logic                         i_relu_en,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [DATA_WIDTH-1:0]        o_out_data,
    output logic                         o_out_last,
    output logic                         o_busy,
    output logic                         o_collect_done,
    output logic                         o_drain_done,
    output logic [15:0]                  o_beat_count
);

    localparam int unsigned PAD = PSUM_WIDTH - DATA_WIDTH + 1;
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = {{PAD{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = {{PAD{1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DRAIN} state_t;

    state_t r_state, w_next_state;
    logic   r_psum_ready, r_busy, r_collect_done, r_drain_done;
    logic   w_collect_done_nxt, w_drain_done_nxt;
    logic [15:0] r_beat_count;

    logic signed [PSUM_WIDTH-1:0] r_ram [BUFFER_SIZE];
    logic signed [PSUM_WIDTH-1:0] r_rd_data;
    logic [AW-1:0]                w_ram_raddr;

    logic                         r_s1_valid, r_s1_accum;
    logic [AW-1:0]                r_s1_addr;
    logic signed [PSUM_WIDTH-1:0] r_s1_data;
    logic                         r_lw_valid;
    logic [AW-1:0]                r_lw_addr;
    logic signed [PSUM_WIDTH-1:0] r_lw_data;
    logic signed [PSUM_WIDTH-1:0] w_operand, w_sum;

    logic [AW:0]                  r_rd_idx, r_drain_len;
    logic                         r_relu, r_rd_pend, r_rd_pend_last;
    logic                         r_out_valid, r_out_last, r_skid_valid, r_skid_last;
    logic [DATA_WIDTH-1:0]        r_out_data, r_skid_data, w_conv;
    logic signed [PSUM_WIDTH-1:0] w_relu_v;
    logic [2:0]                   w_occ;
    logic                         w_accept, w_drain_go, w_pop, w_rd_issue;
    logic                         w_unused_col;

    // Column ID is informational only.
    assign w_unused_col = ^i_psum_col_id;

    assign w_accept   = (r_state == S_COLLECT) && r_psum_ready && i_psum_valid;
    assign w_drain_go = (r_state == S_IDLE) && !i_collect_start && i_drain_start
                        && (i_drain_len != '0);
    assign w_pop      = r_out_valid && i_out_ready;

    // Next-state and done-pulse decode.
    always_comb begin
        w_next_state       = r_state;
        w_collect_done_nxt = 1'b0;
        w_drain_done_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_collect_start) begin
                    w_next_state = S_COLLECT;
                end else if (i_drain_start) begin
                    if (i_drain_len != '0) w_next_state = S_DRAIN;
                    else                   w_drain_done_nxt = 1'b1;
                end
            end
            S_COLLECT: if (w_accept && i_psum_last) w_next_state = S_FLUSH;
            // No accepts in FLUSH, so the final beat's write commits on this edge.
            S_FLUSH: begin
                w_next_state       = S_IDLE;
                w_collect_done_nxt = 1'b1;
            end
            S_DRAIN: begin
                if (w_pop && r_out_last) begin
                    w_next_state     = S_IDLE;
                    w_drain_done_nxt = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_psum_ready   <= 1'b0;
            r_busy         <= 1'b0;
            r_collect_done <= 1'b0;
            r_drain_done   <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_psum_ready   <= (w_next_state == S_COLLECT);
            r_busy         <= (w_next_state != S_IDLE);
            r_collect_done <= w_collect_done_nxt;
            r_drain_done   <= w_drain_done_nxt;
        end
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_count <= '0;
        end else if ((r_state == S_IDLE) && i_collect_start) begin
            r_beat_count <= '0;
        end else if (w_accept && (r_beat_count != 16'hFFFF)) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    // Accumulate stage; forward the previous write because the RAM is read-first.
    assign w_operand = (r_lw_valid && (r_lw_addr == r_s1_addr)) ? r_lw_data : r_rd_data;
    assign w_sum     = (r_s1_accum ? w_operand : '0) + r_s1_data;

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_accum <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
            r_lw_valid <= 1'b0;
            r_lw_addr  <= '0;
            r_lw_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_accum <= i_psum_accum;
                r_s1_addr  <= i_psum_addr;
                r_s1_data  <= i_psum_data;
            end
            if (r_s1_valid) begin
                r_lw_valid <= 1'b1;
                r_lw_addr  <= r_s1_addr;
                r_lw_data  <= w_sum;
            end
        end
    end

    always_comb begin
        unique case (r_state)
            S_COLLECT: w_ram_raddr = i_psum_addr;
            S_DRAIN:   w_ram_raddr = r_rd_idx[AW-1:0];
            default:   w_ram_raddr = '0;
        endcase
    end

    // Psum RAM: contents survive reset.
    always_ff @(posedge bus_clk) begin
        if (r_s1_valid) r_ram[r_s1_addr] <= w_sum;
        r_rd_data <= r_ram[w_ram_raddr];
    end

    // Occupancy after this cycle's pop, so reads keep pace with a 1 word/cycle host.
    assign w_occ      = 3'(r_out_valid) + 3'(r_skid_valid) + 3'(r_rd_pend) - 3'(w_pop);
    assign w_rd_issue = w_drain_go
                        || ((r_state == S_DRAIN) && (r_rd_idx < r_drain_len) && (w_occ < 3'd2));

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_idx       <= '0;
            r_drain_len    <= '0;
            r_relu         <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_issue;
            if (w_drain_go) begin
                r_rd_idx       <= LEN_ONE;
                r_drain_len    <= i_drain_len;
                r_relu         <= i_relu_en;
                r_rd_pend_last <= (i_drain_len == LEN_ONE);
            end else if (w_rd_issue) begin
                r_rd_idx       <= r_rd_idx + LEN_ONE;
                r_rd_pend_last <= (r_rd_idx == (r_drain_len - LEN_ONE));
            end
        end
    end

    always_comb begin
        w_relu_v = (r_relu && r_rd_data[PSUM_WIDTH-1]) ? '0 : r_rd_data;
        if (w_relu_v > SAT_MAX)      w_conv = SAT_MAX[DATA_WIDTH-1:0];
        else if (w_relu_v < SAT_MIN) w_conv = SAT_MIN[DATA_WIDTH-1:0];
        else                         w_conv = w_relu_v[DATA_WIDTH-1:0];
    end

    // Two-entry output FIFO: head register drives the port, skid catches the overflow.
    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_last   <= r_skid_last;
                r_skid_valid <= r_rd_pend;
                if (r_rd_pend) begin
                    r_skid_data <= w_conv;
                    r_skid_last <= r_rd_pend_last;
                end
            end else begin
                r_out_valid <= r_rd_pend;
                r_out_last  <= r_rd_pend && r_rd_pend_last;
                if (r_rd_pend) r_out_data <= w_conv;
            end
        end else if (r_rd_pend) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_conv;
                r_out_last  <= r_rd_pend_last;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_conv;
                r_skid_last  <= r_rd_pend_last;
            end
        end
    end

    assign o_psum_ready   = r_psum_ready;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_out_last     = r_out_last;
    assign o_busy         = r_busy;
    assign o_collect_done = r_collect_done;
    assign o_drain_done   = r_drain_done;
    assign o_beat_count   = r_beat_count;

endmodule

// File: tb/tb_ofmap_glb_collector.sv
// Directed bench for ofmap_glb_collector: expected drain words are queued by the
// stimulus and checked by an independent output monitor.
module tb_ofmap_glb_collector;

    localparam int unsigned AW = 9;

    logic              bus_clk, rstn;
    logic              collect_start, psum_valid, psum_accum, psum_last;
    logic              drain_start, relu_en, out_ready;
    logic [31:0]       psum_data;
    logic [AW-1:0]     psum_addr;
    logic [3:0]        psum_col_id;
    logic [AW:0]       drain_len;
    logic              o_psum_ready, o_out_valid, o_out_last, o_busy;
    logic              o_collect_done, o_drain_done;
    logic [15:0]       o_out_data, o_beat_count;

    typedef struct packed { logic [15:0] d; logic l; } exp_t;
    typedef struct { int addr; int data; bit acc; bit last; } beat_t;

    exp_t  sb_q[$];
    beat_t bq[$];
    int    errors = 0;
    int    checks = 0;
    bit    rand_mode = 0;
    bit    prev_stall = 0;
    logic [15:0] prev_data;
    logic        prev_last;

    ofmap_glb_collector dut (
        .bus_clk(bus_clk), .rstn(rstn),
        .i_collect_start(collect_start), .i_psum_valid(psum_valid), .o_psum_ready(o_psum_ready),
        .i_psum_data(psum_data), .i_psum_addr(psum_addr), .i_psum_col_id(psum_col_id),
        .i_psum_accum(psum_accum), .i_psum_last(psum_last),
        .i_drain_start(drain_start), .i_drain_len(drain_len), .i_relu_en(relu_en),
        .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_data(o_out_data),
        .o_out_last(o_out_last), .o_busy(o_busy), .o_collect_done(o_collect_done),
        .o_drain_done(o_drain_done), .o_beat_count(o_beat_count)
    );

    initial begin
        bus_clk = 1'b0;
        forever #5 bus_clk = ~bus_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    // Host ready: constant 1 or a 50% coin flip per cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge bus_clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor / scoreboard.
    always @(negedge bus_clk) begin
        exp_t e;
        if (!rstn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(o_out_valid), 32'd1);
                chk("stall_data", 32'(o_out_data), 32'(prev_data));
                chk("stall_last", 32'(o_out_last), 32'(prev_last));
            end
            if (o_out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", o_out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 32'(o_out_data), 32'(e.d));
                    chk("out_last", 32'(o_out_last), 32'(e.l));
                end
            end
            prev_stall = o_out_valid && !out_ready;
            prev_data  = o_out_data;
            prev_last  = o_out_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic push_exp(input int d, input bit l);
        exp_t e;
        e.d = 16'(d);
        e.l = l;
        sb_q.push_back(e);
    endtask

    task automatic add_beat(input int addr, input int data, input bit acc, input bit last);
        beat_t b;
        b.addr = addr; b.data = data; b.acc = acc; b.last = last;
        bq.push_back(b);
    endtask

    task automatic start_collect(input bit with_drain);
        collect_start = 1'b1;
        if (with_drain) begin
            drain_start = 1'b1;
            drain_len   = (AW+1)'(4);
        end
        tick();
        collect_start = 1'b0;
        drain_start   = 1'b0;
        chk("ready_rise", 32'(o_psum_ready), 32'd1);
        chk("collect_busy", 32'(o_busy), 32'd1);
        chk("count_clear", 32'(o_beat_count), 32'd0);
    endtask

    task automatic run_beats(input int exp_count);
        beat_t b;
        while (bq.size() > 0) begin
            b = bq.pop_front();
            psum_valid = 1'b1;
            psum_addr  = AW'(b.addr);
            psum_data  = 32'(b.data);
            psum_accum = b.acc;
            psum_last  = b.last;
            psum_col_id = 4'(b.addr);
            tick();
        end
        psum_valid = 1'b0;
        psum_accum = 1'b0;
        psum_last  = 1'b0;
        chk("flush_ready", 32'(o_psum_ready), 32'd0);
        chk("done_early", 32'(o_collect_done), 32'd0);
        chk("flush_busy", 32'(o_busy), 32'd1);
        tick();
        chk("collect_done", 32'(o_collect_done), 32'd1);
        chk("done_busy", 32'(o_busy), 32'd0);
        chk("beat_count", 32'(o_beat_count), 32'(exp_count));
        tick();
        chk("done_pulse", 32'(o_collect_done), 32'd0);
    endtask

    // Expected words must already be queued.
    task automatic do_drain(input int len, input bit relu, input bit timed);
        int n;
        bit done;
        drain_len   = (AW+1)'(len);
        relu_en     = relu;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        relu_en     = 1'b0;
        if (timed) chk("first_valid_early", 32'(o_out_valid), 32'd0);
        n = 1;
        done = 0;
        while (!done && n < 400) begin
            tick();
            n++;
            if (timed && n == 2) chk("first_valid", 32'(o_out_valid), 32'd1);
            if (o_drain_done) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got no drain_done expected drain_done");
        end else begin
            chk("drain_busy", 32'(o_busy), 32'd0);
            chk("sb_empty", 32'(sb_q.size()), 32'd0);
            if (timed) chk("drain_cycles", 32'(n), 32'(len + 2));
        end
        sb_q.delete();
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        collect_start = 1'b0; psum_valid = 1'b0; psum_accum = 1'b0; psum_last = 1'b0;
        drain_start = 1'b0; relu_en = 1'b0; psum_data = '0; psum_addr = '0;
        psum_col_id = '0; drain_len = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(o_psum_ready), 32'd0);
        chk("rst_valid", 32'(o_out_valid), 32'd0);
        chk("rst_data", 32'(o_out_data), 32'd0);
        chk("rst_last", 32'(o_out_last), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cdone", 32'(o_collect_done), 32'd0);
        chk("rst_ddone", 32'(o_drain_done), 32'd0);
        chk("rst_count", 32'(o_beat_count), 32'd0);
        rstn = 1'b1;
        tick();

        // Clear addresses 0..15.
        start_collect(0);
        for (int i = 0; i < 16; i++) add_beat(i, 0, 0, i == 15);
        run_beats(16);

        // Overwrite a single word.
        start_collect(0);
        add_beat(5, 100, 0, 1);
        run_beats(1);
        for (int i = 0; i < 5; i++) push_exp(0, 0);
        push_exp(100, 1);
        do_drain(6, 0, 1);

        // Back-to-back accumulate (forwarded) and gapped accumulate (from RAM).
        start_collect(0);
        add_beat(3, 10, 0, 0); add_beat(3, 20, 1, 0); add_beat(3, -5, 1, 0);
        add_beat(6, 7, 0, 0);  add_beat(7, 1, 0, 0);  add_beat(6, 3, 1, 0);
        add_beat(4, 0, 0, 1);
        run_beats(7);
        push_exp(0, 0); push_exp(0, 0); push_exp(0, 0); push_exp(25, 0);
        push_exp(0, 0); push_exp(100, 0); push_exp(10, 0); push_exp(1, 1);
        do_drain(8, 0, 1);

        // Saturation and ReLU.
        start_collect(0);
        add_beat(0, 40000, 0, 0); add_beat(1, -40000, 0, 0); add_beat(2, -100, 0, 0);
        add_beat(3, 5, 0, 0); add_beat(4, 32767, 0, 0); add_beat(5, -32768, 0, 0);
        add_beat(6, 32768, 0, 1);
        run_beats(7);
        push_exp(16'h7FFF, 0); push_exp(16'h8000, 0); push_exp(16'hFF9C, 0);
        push_exp(16'h0005, 0); push_exp(16'h7FFF, 0); push_exp(16'h8000, 0);
        push_exp(16'h7FFF, 1);
        do_drain(7, 0, 1);
        push_exp(16'h7FFF, 0); push_exp(0, 0); push_exp(0, 0);
        push_exp(16'h0005, 0); push_exp(16'h7FFF, 0); push_exp(0, 0);
        push_exp(16'h7FFF, 1);
        do_drain(7, 1, 1);

        // Random host backpressure.
        start_collect(0);
        for (int i = 0; i < 8; i++) add_beat(i, i * 100 - 300, 0, i == 7);
        run_beats(8);
        rand_mode = 1;
        for (int i = 0; i < 8; i++) push_exp(i * 100 - 300, i == 7);
        do_drain(8, 0, 0);
        rand_mode = 0;
        tick();

        // Zero-length drain only pulses drain_done.
        drain_len = '0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("len0_done", 32'(o_drain_done), 32'd1);
        chk("len0_busy", 32'(o_busy), 32'd0);
        tick();
        chk("len0_pulse", 32'(o_drain_done), 32'd0);

        // Simultaneous starts pick collect; drain_start during COLLECT is ignored.
        start_collect(1);
        drain_len = (AW+1)'(4);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("ign_ready", 32'(o_psum_ready), 32'd1);
        tick();
        chk("ign_valid", 32'(o_out_valid), 32'd0);
        tick();
        chk("ign_valid2", 32'(o_out_valid), 32'd0);
        add_beat(8, 55, 0, 1);
        run_beats(1);

        // Reset in the middle of a drain, then a fresh drain.
        for (int i = 0; i < 8; i++) push_exp(i * 100 - 300, i == 7);
        drain_len = (AW+1)'(8);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_out_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_count", 32'(o_beat_count), 32'd0);
        sb_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        tick();
        push_exp(16'hFED4, 0); push_exp(16'hFF38, 0); push_exp(16'hFF9C, 1);
        do_drain(3, 0, 1);

        // Accumulator wraps modulo 2^32.
        start_collect(0);
        add_beat(0, 32'h7FFFFFFF, 0, 0);
        add_beat(0, 1, 1, 1);
        run_beats(2);
        push_exp(16'h8000, 1);
        do_drain(1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
